fsm_decoder: RTL

FSM_DECODER -- requirements
Module: fsm_decoder

---
 rtl/fsm_decoder_if.sv | 31 +++
 rtl/fsm_decoder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fsm_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : fsm_decoder_if
// Brief   : Sample-in / decode-out bundle for the i/j state-trace decoder.
// Revision: 1.0
// ============================================================================
interface fsm_decoder_if #(
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic             x;
    logic             y;
    logic             out_valid;
    logic             i_out;
    logic             j_out;
    logic             j_known;
    logic             err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, x, y,
        input  out_valid, i_out, j_out, j_known, err, locked, err_cnt
    );

    modport slave (
        input  in_valid, x, y,
        output out_valid, i_out, j_out, j_known, err, locked, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fsm_decoder.sv
`default_nettype none
// ============================================================================
// Module  : fsm_decoder
// Brief   : Recovers i/j from a 4-state trace; flags illegal hops and relocks.
// Revision: 1.0
// ============================================================================
module fsm_decoder #(
    parameter int ERR_W  = 8,
    parameter int RELOCK = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fsm_decoder_if.slave   bus
);
    typedef enum logic [0:0] {
        LOCK   = 1'b0,
        RESYNC = 1'b1
    } mode_t;

    localparam logic [1:0]       c_ST_A     = 2'b11;
    localparam logic [1:0]       c_ST_B     = 2'b10;
    localparam logic [1:0]       c_ST_C     = 2'b01;
    localparam logic [1:0]       c_ST_D     = 2'b00;
    localparam logic [3:0]       c_RELOCK   = 4'(RELOCK);
    localparam logic [ERR_W-1:0] c_ERR_MAX  = '1;
    localparam logic [ERR_W-1:0] c_ERR_ONE  = ERR_W'(1);

    logic [1:0]       prev_q, prev_d;
    mode_t            mode_q, mode_d;
    logic [3:0]       relock_q, relock_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             i_q, i_d;
    logic             jk_q, jk_d;
    logic             j_q, j_d;
    logic             err_q, err_d;

    logic [1:0]       w_sample;
    logic             w_legal;
    logic             w_i;
    logic             w_jk;
    logic             w_j;

    assign w_sample = {bus.x, bus.y};

    // Transition table: {legal, i, j_known, j}; j stays 0 whenever j_known is 0.
    always_comb begin
        {w_legal, w_i, w_jk, w_j} = 4'b0000;
        case ({prev_q, w_sample})
            {c_ST_A, c_ST_A}: {w_legal, w_i, w_jk, w_j} = 4'b1000;
            {c_ST_A, c_ST_B}: {w_legal, w_i, w_jk, w_j} = 4'b1100;
            {c_ST_B, c_ST_C}: {w_legal, w_i, w_jk, w_j} = 4'b1100;
            {c_ST_B, c_ST_D}: {w_legal, w_i, w_jk, w_j} = 4'b1000;
            {c_ST_C, c_ST_B}: {w_legal, w_i, w_jk, w_j} = 4'b1100;
            {c_ST_C, c_ST_C}: {w_legal, w_i, w_jk, w_j} = 4'b1011;
            {c_ST_C, c_ST_D}: {w_legal, w_i, w_jk, w_j} = 4'b1010;
            {c_ST_D, c_ST_D}: {w_legal, w_i, w_jk, w_j} = 4'b1100;
            {c_ST_D, c_ST_C}: {w_legal, w_i, w_jk, w_j} = 4'b1011;
            {c_ST_D, c_ST_A}: {w_legal, w_i, w_jk, w_j} = 4'b1010;
            default:          {w_legal, w_i, w_jk, w_j} = 4'b0000;
        endcase
    end

    always_comb begin
        prev_d      = prev_q;
        mode_d      = mode_q;
        relock_d    = relock_q;
        err_cnt_d   = err_cnt_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        i_d         = i_q;
        jk_d        = jk_q;
        j_d         = j_q;

        if (bus.in_valid) begin
            prev_d = w_sample;
            if (w_legal) begin
                if (mode_q == LOCK) begin
                    out_valid_d = 1'b1;
                    i_d         = w_i;
                    jk_d        = w_jk;
                    j_d         = w_j;
                end else if (relock_q + 4'd1 == c_RELOCK) begin
                    mode_d   = LOCK;
                    relock_d = 4'd0;
                end else begin
                    relock_d = relock_q + 4'd1;
                end
            end else begin
                err_d    = 1'b1;
                mode_d   = RESYNC;
                relock_d = 4'd0;
                if (err_cnt_q != c_ERR_MAX) begin
                    err_cnt_d = err_cnt_q + c_ERR_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= c_ST_A;
            mode_q      <= LOCK;
            relock_q    <= 4'd0;
            err_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            i_q         <= 1'b0;
            jk_q        <= 1'b0;
            j_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            mode_q      <= mode_d;
            relock_q    <= relock_d;
            err_cnt_q   <= err_cnt_d;
            out_valid_q <= out_valid_d;
            i_q         <= i_d;
            jk_q        <= jk_d;
            j_q         <= j_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.i_out     = i_q;
    assign bus.j_known   = jk_q;
    assign bus.j_out     = j_q;
    assign bus.err       = err_q;
    assign bus.locked    = (mode_q == LOCK);
    assign bus.err_cnt   = err_cnt_q;
endmodule
`default_nettype wire
